// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap/MRET sequencer:
// CSR addresses, mstatus bit positions, the FSM state type and the
// mstatus rewrite helpers used on trap entry and MRET.
package csr_pkg;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_R_MSTATUS,
    S_W_MSTATUS,
    S_R_MTVEC,
    S_MR_RSTAT,
    S_MR_WSTAT,
    S_MR_RMEPC,
    S_REDIRECT
  } state_t;

  // Trap entry: stash MIE into MPIE, mask interrupts, record M as previous mode.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = cur;
    nxt[MSTATUS_MPIE] = cur[MSTATUS_MIE];
    nxt[MSTATUS_MIE]  = 1'b0;
    nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return nxt;
  endfunction

  // MRET: restore MIE from MPIE, set MPIE, drop previous mode to U.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = cur;
    nxt[MSTATUS_MIE]  = cur[MSTATUS_MPIE];
    nxt[MSTATUS_MPIE] = 1'b1;
    nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    return nxt;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// Bundle between the trap controller and its surroundings (pipeline
// request side, CSR file port, fetch redirect).
// master: the trap controller itself. slave: pipeline + CSR file.
interface csr_trap_ctrl_if;
  logic        trap_req_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_pc_i;
  logic        mret_req_i;
  logic        trap_ack_o;
  logic        mret_ack_o;
  logic        busy_o;
  logic [31:0] csr_addr_o;
  logic        csr_we_o;
  logic        csr_re_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  modport master (
    input  trap_req_i, trap_cause_i, trap_pc_i, mret_req_i, csr_rdata_i,
    output trap_ack_o, mret_ack_o, busy_o, csr_addr_o, csr_we_o, csr_re_o,
           csr_wdata_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    output trap_req_i, trap_cause_i, trap_pc_i, mret_req_i, csr_rdata_i,
    input  trap_ack_o, mret_ack_o, busy_o, csr_addr_o, csr_we_o, csr_re_o,
           csr_wdata_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/csr_trap_vec.sv
// Trap target computation from mtvec and the latched cause.
// Optional feature: define TRAP_VECTORED_EN to honour mtvec vectored mode
// (mode 2'b01) for interrupts; otherwise the target is always the base.
module csr_trap_vec (
  input  logic [31:0] mtvec_i,
  input  logic [31:0] cause_i,
  output logic [31:0] target_o
);

  logic [31:0] base;
  assign base = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Interrupts in vectored mode jump to base + 4*code, wrapping mod 2^32.
  always_comb begin
    // NOTE: a default first keeps every path assigned, so no latch is inferred.
    target_o = base;
    if (mtvec_i[1:0] == 2'b01 && cause_i[31])
      target_o = base + (32'(cause_i[30:0]) << 2);
  end
`else
  // Direct mode only: mode bits and cause do not affect the target.
  logic unused_vec;
  assign unused_vec = ^{mtvec_i[1:0], cause_i};
  assign target_o   = base;
`endif

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer. Walks the CSR file through the
// mepc/mcause/mstatus updates, then issues a one-cycle fetch redirect.
// Optional feature macro: TRAP_VECTORED_EN (vectored mtvec, see csr_trap_vec).
module csr_trap_ctrl
  import csr_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  csr_trap_ctrl_if.master bus
);

  state_t      state_q;
  logic [31:0] cause_q;
  logic [31:0] pc_q;
  logic        is_mret_q;

  logic        trap_take;
  logic        mret_take;
  logic [31:0] trap_target;

  logic [31:0] csr_addr;
  logic        csr_we;
  logic        csr_re;
  logic [31:0] csr_wdata;
  logic        redir_valid;
  logic [31:0] redir_pc;

  // Acceptance only in IDLE; trap wins over MRET; reset masks the acks.
  assign trap_take = (state_q == S_IDLE) && bus.trap_req_i && !rst_i;
  assign mret_take = (state_q == S_IDLE) && bus.mret_req_i && !bus.trap_req_i && !rst_i;

  csr_trap_vec u_trap_vec (
    .mtvec_i  (bus.csr_rdata_i),
    .cause_i  (cause_q),
    .target_o (trap_target)
  );

  // Sequencer state plus the trap context latched at acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cause_q   <= '0;
      pc_q      <= '0;
      is_mret_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (trap_take) begin
            state_q   <= S_W_MEPC;
            cause_q   <= bus.trap_cause_i;
            pc_q      <= bus.trap_pc_i;
            is_mret_q <= 1'b0;
          end else if (mret_take) begin
            state_q   <= S_MR_RSTAT;
            is_mret_q <= 1'b1;
          end
        end
        S_W_MEPC:    state_q <= S_W_MCAUSE;
        S_W_MCAUSE:  state_q <= S_R_MSTATUS;
        S_R_MSTATUS: state_q <= S_W_MSTATUS;
        S_W_MSTATUS: state_q <= S_R_MTVEC;
        S_R_MTVEC:   state_q <= S_REDIRECT;
        S_MR_RSTAT:  state_q <= S_MR_WSTAT;
        S_MR_WSTAT:  state_q <= S_MR_RMEPC;
        S_MR_RMEPC:  state_q <= S_REDIRECT;
        S_REDIRECT:  state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  // State-decoded CSR strobes and redirect; read data arrives one cycle
  // after the read strobe, i.e. in the state following each read state.
  always_comb begin
    csr_addr    = '0;
    csr_we      = 1'b0;
    csr_re      = 1'b0;
    csr_wdata   = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    case (state_q)
      S_W_MEPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = pc_q;
      end
      S_W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
      end
      S_R_MSTATUS, S_MR_RSTAT: begin
        csr_re   = 1'b1;
        csr_addr = CSR_MSTATUS;
      end
      S_W_MSTATUS: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = trap_mstatus(bus.csr_rdata_i);
      end
      S_R_MTVEC: begin
        csr_re   = 1'b1;
        csr_addr = CSR_MTVEC;
      end
      S_MR_WSTAT: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mret_mstatus(bus.csr_rdata_i);
      end
      S_MR_RMEPC: begin
        csr_re   = 1'b1;
        csr_addr = CSR_MEPC;
      end
      S_REDIRECT: begin
        redir_valid = 1'b1;
        redir_pc    = is_mret_q ? {bus.csr_rdata_i[31:1], 1'b0} : trap_target;
      end
      default: ;
    endcase
  end

  assign bus.trap_ack_o       = trap_take;
  assign bus.mret_ack_o       = mret_take;
  assign bus.busy_o           = (state_q != S_IDLE);
  assign bus.csr_addr_o       = csr_addr;
  assign bus.csr_we_o         = csr_we;
  assign bus.csr_re_o         = csr_re;
  assign bus.csr_wdata_o      = csr_wdata;
  assign bus.redirect_valid_o = redir_valid;
  assign bus.redirect_pc_o    = redir_pc;

endmodule

// File: doc/csr_trap_ctrl.md
CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have clk_i input 1: rising-edge clock.
REQ-002 SHALL have rst_i input 1: reset, asynchronous, active-high.
REQ-003 SHALL have trap_req_i input 1: trap request, held high until trap_ack_o.
REQ-004 SHALL have trap_cause_i input 32: mcause value; bit 31 set means interrupt.
REQ-005 SHALL have trap_pc_i input 32: PC of the trapping instruction.
REQ-006 SHALL have mret_req_i input 1: MRET request, held high until mret_ack_o.
REQ-007 SHALL have trap_ack_o / mret_ack_o output 1 each: one-cycle acceptance pulses.
REQ-008 SHALL have busy_o output 1: high whenever the FSM is not in IDLE.
REQ-009 SHALL have csr_addr_o output 32, csr_we_o output 1, csr_re_o output 1, csr_wdata_o output 32: CSR file port.
REQ-010 SHALL have csr_rdata_i input 32: CSR file read data, valid the cycle after csr_re_o.
REQ-011 SHALL have redirect_valid_o output 1 and redirect_pc_o output 32: one-cycle fetch redirect.

Function
REQ-012 SHALL implement the FSM states IDLE, W_MEPC, W_MCAUSE, R_MSTATUS, W_MSTATUS, R_MTVEC, MR_RSTAT, MR_WSTAT, MR_RMEPC and REDIRECT, with Moore-decoded CSR strobes.
REQ-013 SHALL, in IDLE with trap_req_i high at edge T, pulse trap_ack_o during cycle T and latch cause and pc.
- Sequence: W_MEPC(T+1) -> W_MCAUSE(T+2) -> R_MSTATUS(T+3) -> W_MSTATUS(T+4) -> R_MTVEC(T+5) -> REDIRECT(T+6) -> IDLE.
REQ-014 SHALL, in IDLE with mret_req_i high, pulse mret_ack_o.
- Sequence: MR_RSTAT(T+1) -> MR_WSTAT(T+2) -> MR_RMEPC(T+3) -> REDIRECT(T+4) -> IDLE.
REQ-015 SHALL drive the CSR port per state:
- W_MEPC: write 0x341 = latched pc.
- W_MCAUSE: write 0x342 = latched cause.
- R_MSTATUS / MR_RSTAT: read 0x300.
- R_MTVEC: read 0x305.
- MR_RMEPC: read 0x341.
- All other states: csr_we_o=csr_re_o=0, addr=0, wdata=0.
REQ-016 SHALL, in W_MSTATUS, write 0x300 with csr_rdata_i modified as: MPIE(bit7)=MIE(bit3), MIE=0, MPP(bits12:11)=2'b11; all other bits unchanged.
REQ-017 SHALL, in MR_WSTAT, write 0x300 with MIE=MPIE, MPIE=1, MPP=2'b00.
REQ-018 SHALL, on trap redirect, set redirect_pc_o={csr_rdata_i[31:2],2'b00}; on mret redirect, set redirect_pc_o={csr_rdata_i[31:1],1'b0}.
REQ-019 SHALL assert redirect_valid_o only in REDIRECT; at all other times redirect_pc_o=0.
REQ-020 SHALL give trap priority over MRET when both requests are high in IDLE; the MRET is not acked.
REQ-021 SHALL ignore requests while busy_o=1; no queuing.
REQ-022 SHALL use 32-bit address arithmetic wrapping modulo 2^32.

Reset
REQ-023 SHALL, on rst_i, force IDLE asynchronously and drive every output to 0, including mid-sequence; the interrupted sequence is abandoned with no redirect.
REQ-024 SHALL clear latched cause/pc to 0 on reset.

Configuration
REQ-025 SHALL, with TRAP_VECTORED_EN defined, mtvec[1:0]==2'b01 and latched cause bit31=1, set the trap target to {mtvec[31:2],2'b00} + 4*cause[30:0].
REQ-026 SHALL, without TRAP_VECTORED_EN, always use direct mode per REQ-018 and ignore mtvec[1:0].

Structure
REQ-027 SHALL place the CSR address constants, mstatus bit positions and FSM state typedef in shared package csr_pkg.
REQ-028 SHALL compute the trap target in sub-module csr_trap_vec (combinational; mtvec + cause in, target out).

Verification
REQ-029 SHALL cover trap cause=0x2, pc=0x100, mstatus=0x8, mtvec=0x400:
- Writes 0x341=0x100, 0x342=0x2, 0x300=0x1880.
- redirect_pc_o=0x400 at T+6.
REQ-030 SHALL cover mret with mstatus=0x1880, mepc=0x104:
- Writes 0x300=0x88.
- redirect_pc_o=0x104 at T+4.
REQ-031 SHALL cover trap_req_i and mret_req_i high together: only trap_ack_o pulses; after the trap redirect, the still-held mret is accepted.
REQ-032 SHALL cover rst_i asserted at T+3 of a trap: all outputs 0 immediately, no redirect, next trap runs from W_MEPC.
REQ-033 SHALL cover, with TRAP_VECTORED_EN, mtvec=0x401 and cause=0x80000007: redirect_pc_o=0x41C; without the macro: 0x400.
REQ-034 SHALL cover trap_req_i pulsed while busy_o=1: no ack, no extra CSR writes.
